// File: rtl/interface_hcsr04.sv
// HC-SR04 ranger: on medir, fires a TRIG_CYCLES trigger pulse, times the echo, reports rounded cm as 3 BCD digits.
// Latency: 2 clocks (preparacao + trigger start) to trigger, echo sync 2 clocks, result 2 clocks after echo fall.
// Backpressure: none; medir is only honoured in inicial/final, and the result is held with pronto until the next request.
module interface_hcsr04 #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2941,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        db_reset,
  output logic        db_medir,
  output logic [3:0]  db_estado
);

  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int CW = $clog2(CM_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] CM_LAST   = CW'(CM_CYCLES - 1);
  localparam logic [CW-1:0] CM_HALF   = CW'(CM_CYCLES / 2);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_CYCLES - 1);

  // The counting scheme needs a wrap point above 1 and non-empty trigger/timeout windows.
  if (CLK_HZ <= 0 || TRIG_CYCLES < 1 || CM_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("interface_hcsr04: invalid parameter set");
  end

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'd0,
    ST_PREPARACAO    = 4'd1,
    ST_ENVIA_TRIGGER = 4'd2,
    ST_ESPERA_ECHO   = 4'd3,
    ST_MEDINDO       = 4'd4,
    ST_ARMAZENA      = 4'd5,
    ST_FINAL         = 4'd6,
    ST_TIMEOUT       = 4'd7
  } state_t;

  state_t        state, state_next;
  logic          echo_meta, echo_sync;
  logic [TW-1:0] trig_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [OW-1:0] to_cnt;
  logic [11:0]   bcd_cnt;

  // Saturating 3-digit BCD increment; 999 stays 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  // Two-flop synchroniser for the asynchronous echo pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_INICIAL;
    else        state <= state_next;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_next = state;
    trigger    = 1'b0;
    pronto     = 1'b0;
    case (state)
      ST_INICIAL:       if (medir) state_next = ST_PREPARACAO;
      ST_PREPARACAO:    state_next = ST_ENVIA_TRIGGER;
      ST_ENVIA_TRIGGER: begin
        trigger = 1'b1;
        if (trig_cnt == TRIG_LAST) state_next = ST_ESPERA_ECHO;
      end
      ST_ESPERA_ECHO: begin
        if (echo_sync)              state_next = ST_MEDINDO;
        else if (to_cnt == TO_LAST) state_next = ST_TIMEOUT;
      end
      ST_MEDINDO:       if (!echo_sync) state_next = ST_ARMAZENA;
      ST_ARMAZENA:      state_next = ST_FINAL;
      ST_TIMEOUT:       state_next = ST_FINAL;
      ST_FINAL: begin
        pronto = 1'b1;
        if (medir) state_next = ST_PREPARACAO;
      end
      default:          state_next = ST_INICIAL;
    endcase
  end

  // Counters and result register. The first echo-high clock is seen in espera_echo, so the
  // cycle counter is seeded with 1 there; the total echo width is bcd_cnt*CM_CYCLES + cyc_cnt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_cnt <= '0;
      cyc_cnt  <= '0;
      to_cnt   <= '0;
      bcd_cnt  <= 12'h000;
      medida   <= 12'h000;
    end else begin
      case (state)
        ST_PREPARACAO: begin
          trig_cnt <= '0;
          cyc_cnt  <= '0;
          to_cnt   <= '0;
          bcd_cnt  <= 12'h000;
        end
        ST_ENVIA_TRIGGER: trig_cnt <= trig_cnt + TW'(1);
        ST_ESPERA_ECHO: begin
          to_cnt <= to_cnt + OW'(1);
          if (echo_sync) cyc_cnt <= CW'(1);
        end
        ST_MEDINDO: begin
          if (echo_sync) begin
            if (cyc_cnt == CM_LAST) begin
              cyc_cnt <= '0;
              bcd_cnt <= bcd_inc(bcd_cnt);
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end else if (cyc_cnt >= CM_HALF) begin
            // Round to nearest centimetre on the falling edge.
            bcd_cnt <= bcd_inc(bcd_cnt);
          end
        end
        ST_ARMAZENA: medida <= bcd_cnt;
        ST_TIMEOUT:  medida <= 12'h000;
        default: ;
      endcase
    end
  end

  assign db_reset  = reset;
  assign db_medir  = medir;
  assign db_estado = state;

endmodule

// File: tb/tb_interface_hcsr04.sv
module tb_interface_hcsr04;

  localparam int TRIG = 10;
  localparam int CM   = 20;
  localparam int TOUT = 400;

  logic        clock;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        db_reset;
  logic        db_medir;
  logic [3:0]  db_estado;

  int checks;
  int errors;

  interface_hcsr04 #(
    .CLK_HZ(50_000_000),
    .TRIG_CYCLES(TRIG),
    .CM_CYCLES(CM),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .medir(medir),
    .echo(echo),
    .trigger(trigger),
    .medida(medida),
    .pronto(pronto),
    .db_reset(db_reset),
    .db_medir(db_medir),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic wait_estado(input logic [3:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (db_estado == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Start a measurement, wait for espera_echo, delay, send an echo of 'width' clocks, wait for final.
  task automatic run_measure(input int gap, input int width, output bit ok, output logic pronto_at_start);
    bit w;
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    pronto_at_start = pronto;
    wait_estado(4'd3, 100, w);
    repeat (gap) @(negedge clock);
    echo = 1'b1;
    repeat (width) @(negedge clock);
    echo = 1'b0;
    wait_estado(4'd6, 50, ok);
    ok = ok && w;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    medir = 1'b0;
    echo  = 1'b0;
    repeat (100) @(negedge clock);
    checks++;
    if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger: got %b want 0", trigger); end
    checks++;
    if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b want 0", pronto); end
    checks++;
    if (medida !== 12'h000) begin errors++; $display("FAIL reset_medida: got %h want 000", medida); end
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
    checks++;
    if (db_reset !== 1'b0) begin errors++; $display("FAIL reset_db_reset_low: got %b want 0", db_reset); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_reset !== 1'b1) begin errors++; $display("FAIL reset_db_reset_high: got %b want 1", db_reset); end
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_estado: got %0d want 0", db_estado); end
  endtask

  task automatic test_trigger;
    int first_high, highs, est1, est_fall;
    bit fell, ok;
    first_high = -1; highs = 0; est1 = -1; est_fall = -1; fell = 1'b0;
    @(negedge clock);
    medir = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clock);
      if (k == 1) begin
        est1 = db_estado;
        checks++;
        if (db_medir !== 1'b1) begin errors++; $display("FAIL db_medir: got %b want 1", db_medir); end
      end
      if (k == 5) medir = 1'b0;
      if (trigger) begin
        if (first_high < 0) first_high = k;
        highs++;
      end else if (first_high >= 0) begin
        est_fall = db_estado;
        fell = 1'b1;
        break;
      end
    end
    medir = 1'b0;
    checks++;
    if (est1 != 1) begin errors++; $display("FAIL trig_estado1: got %0d want 1", est1); end
    checks++;
    if (first_high != 2) begin errors++; $display("FAIL trig_start: got %0d want 2", first_high); end
    checks++;
    if (!fell || highs != TRIG) begin errors++; $display("FAIL trig_width: got %0d want %0d", highs, TRIG); end
    checks++;
    if (est_fall != 3) begin errors++; $display("FAIL trig_estado3: got %0d want 3", est_fall); end
    wait_estado(4'd6, TOUT + 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL trig_reach_final: got timeout want estado 6"); end
  endtask

  task automatic test_measure(input int width, input logic [11:0] exp, input string name);
    bit ok;
    logic p0;
    run_measure(20, width, ok, p0);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_final: got timeout want estado 6", name); end
    checks++;
    if (pronto !== 1'b1) begin errors++; $display("FAIL %s_pronto: got %b want 1", name, pronto); end
    checks++;
    if (medida !== exp) begin errors++; $display("FAIL %s_medida: got %h want %h", name, medida, exp); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n3;
    int e_next, e_next2;
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_estado(4'd3, 100, ok);
    n3 = ok ? 1 : 0;
    for (int i = 0; i < TOUT + 20 && ok; i++) begin
      @(negedge clock);
      if (db_estado != 4'd3) break;
      n3++;
    end
    e_next = db_estado;
    @(negedge clock);
    e_next2 = db_estado;
    checks++;
    if (n3 != TOUT) begin errors++; $display("FAIL tout_wait: got %0d want %0d", n3, TOUT); end
    checks++;
    if (e_next != 7) begin errors++; $display("FAIL tout_estado7: got %0d want 7", e_next); end
    checks++;
    if (e_next2 != 6) begin errors++; $display("FAIL tout_estado6: got %0d want 6", e_next2); end
    checks++;
    if (medida !== 12'h000) begin errors++; $display("FAIL tout_medida: got %h want 000", medida); end
    // Late echo while in final must be ignored.
    echo = 1'b1;
    repeat (150) @(negedge clock);
    echo = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (medida !== 12'h000 || pronto !== 1'b1 || db_estado !== 4'd6) begin
      errors++;
      $display("FAIL tout_late_echo: got medida=%h pronto=%b estado=%0d want 000/1/6", medida, pronto, db_estado);
    end
  endtask

  task automatic test_back_to_back;
    int          widths [4];
    logic [11:0] exps   [4];
    bit ok;
    logic p0;
    widths = '{40, 30, 29, 219};
    exps   = '{12'h002, 12'h002, 12'h001, 12'h011};
    for (int i = 0; i < 4; i++) begin
      repeat (100) @(negedge clock);
      run_measure(5 + i, widths[i], ok, p0);
      checks++;
      if (p0 !== 1'b0) begin errors++; $display("FAIL b2b%0d_pronto_clear: got %b want 0", i, p0); end
      checks++;
      if (!ok || medida !== exps[i] || pronto !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d_result: got medida=%h pronto=%b want %h/1", i, medida, pronto, exps[i]);
      end
    end
  endtask

  task automatic test_saturation;
    test_measure(20500, 12'h999, "sat");
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit ok2;
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_estado(4'd3, 100, ok);
    repeat (10) @(negedge clock);
    echo = 1'b1;
    repeat (100) @(negedge clock);
    checks++;
    if (!ok || db_estado !== 4'd4) begin errors++; $display("FAIL mid_in_medindo: got %0d want 4", db_estado); end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (db_estado !== 4'd0 || trigger !== 1'b0 || medida !== 12'h000 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got estado=%0d trig=%b medida=%h pronto=%b want 0/0/000/0",
               db_estado, trigger, medida, pronto);
    end
    echo = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    wait_estado(4'd0, 5, ok2);
    checks++;
    if (!ok2) begin errors++; $display("FAIL mid_after_release: got estado=%0d want 0", db_estado); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_trigger();
    test_measure(1500, 12'h075, "norm75");
    test_measure(99,   12'h005, "norm5");
    test_measure(1509, 12'h075, "round_down");
    test_measure(1510, 12'h076, "round_up");
    test_timeout();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
